// File: rtl/instr_fetch_responder.sv
// ============================================================================
// Module      : instr_fetch_responder
// Description : Accepts a fetch address, reads four big-endian bytes from a
//               byte-wide synchronous memory, returns the assembled word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_responder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_instr,
    output logic [31:0]       resp_addr,
    output logic              resp_err,
    input  logic              resp_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_beat;
    logic        r_rd_en_d;
    logic        w_bad_addr;
    logic        w_accept;

    assign w_bad_addr = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W] != '0);
    assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = (r_state == S_IDLE);
        resp_valid   = (r_state == S_RESP);
        case (r_state)
            S_IDLE:  if (req_valid) w_state_next = w_bad_addr ? S_RESP : S_FETCH;
            S_FETCH: if (r_beat == 2'd3) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_RESP;
            S_RESP:  if (resp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Redirect overrides everything, including a pending acceptance.
        if (flush) w_state_next = S_IDLE;
    end

    // Memory returns data one cycle after the strobe, so capture follows a
    // delayed copy of mem_rd_en; flush clears it to drop in-flight bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat     <= 2'd0;
            r_rd_en_d  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_instr <= 32'd0;
            resp_addr  <= 32'd0;
            resp_err   <= 1'b0;
        end else if (flush) begin
            r_beat    <= 2'd0;
            r_rd_en_d <= 1'b0;
            mem_rd_en <= 1'b0;
        end else begin
            r_rd_en_d <= mem_rd_en;
            if (r_rd_en_d) begin
                resp_instr <= {resp_instr[23:0], mem_rdata};
            end
            if (w_accept) begin
                resp_addr <= req_addr;
                if (w_bad_addr) begin
                    resp_err   <= 1'b1;
                    resp_instr <= 32'd0;
                end else begin
                    resp_err  <= 1'b0;
                    r_beat    <= 2'd0;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= req_addr[ADDR_W-1:0];
                end
            end
            if (r_state == S_FETCH) begin
                r_beat <= r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_responder.sv
// ============================================================================
// Module      : tb_instr_fetch_responder
// Description : Directed self-checking bench for instr_fetch_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_responder;

    localparam int C_ADDR_W = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic                req_valid;
    logic [31:0]         req_addr;
    logic                req_ready;
    logic                mem_rd_en;
    logic [C_ADDR_W-1:0] mem_addr;
    logic [7:0]          mem_rdata;
    logic                resp_valid;
    logic [31:0]         resp_instr;
    logic [31:0]         resp_addr;
    logic                resp_err;
    logic                resp_ready;

    logic [7:0] mem [0:(1<<C_ADDR_W)-1];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    instr_fetch_responder #(.ADDR_W(C_ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"},  32'(mem_rd_en),  32'd0);
        check({tag, "_maddr"},  32'(mem_addr),   32'd0);
        check({tag, "_valid"},  32'(resp_valid), 32'd0);
        check({tag, "_instr"},  resp_instr,      32'd0);
        check({tag, "_raddr"},  resp_addr,       32'd0);
        check({tag, "_err"},    32'(resp_err),   32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] exp_instr,
                           input logic exp_err, input int stall);
        int lat;
        int rd;
        req_valid  = 1'b1;
        req_addr   = addr;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        rd  = 0;
        while (!resp_valid && lat < 20) begin
            if (mem_rd_en) begin
                check("mem_addr_seq", 32'(mem_addr), (addr & 32'h3FF) + 32'(rd));
                rd++;
            end
            @(negedge clk);
            lat++;
        end
        check("resp_latency", 32'(lat), exp_err ? 32'd1 : 32'd6);
        check("rd_beats",     32'(rd),  exp_err ? 32'd0 : 32'd4);
        check("resp_instr",   resp_instr, exp_instr);
        check("resp_addr",    resp_addr,  addr);
        check("resp_err",     32'(resp_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_instr", resp_instr, exp_instr);
            check("stall_addr",  resp_addr,  addr);
            check("stall_err",   32'(resp_err), 32'(exp_err));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_drop", 32'(resp_valid), 32'd0);
        check("ready_back", 32'(req_ready),  32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1<<C_ADDR_W); i++) mem[i] = 8'h00;
        mem[10'h040] = 8'h20; mem[10'h041] = 8'h08; mem[10'h042] = 8'h00; mem[10'h043] = 8'h05;
        mem[10'h044] = 8'h00; mem[10'h045] = 8'h00; mem[10'h046] = 8'h00; mem[10'h047] = 8'h0C;
        mem[10'h3FC] = 8'hDE; mem[10'h3FD] = 8'hAD; mem[10'h3FE] = 8'hBE; mem[10'h3FF] = 8'hEF;

        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0;
        @(negedge clk);
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Basic aligned fetch, then misaligned, out-of-range and top-word cases
        run_req(32'h0000_0040, 32'h2008_0005, 1'b0, 0);
        run_req(32'h0000_0042, 32'h0000_0000, 1'b1, 0);
        run_req(32'h0000_0400, 32'h0000_0000, 1'b1, 0);
        run_req(32'h0000_03FC, 32'hDEAD_BEEF, 1'b0, 0);
        run_req(32'h8000_0040, 32'h0000_0000, 1'b1, 0);

        // Back-pressure on the response, then confirm no second response
        run_req(32'h0000_0040, 32'h2008_0005, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("one_resp_only", 32'(resp_valid), 32'd0);
        end

        // Flush in idle beats a simultaneous request
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0040;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("flush_idle_rd",    32'(mem_rd_en), 32'd0);
        check("flush_idle_ready", 32'(req_ready), 32'd1);
        check("flush_idle_addr",  resp_addr,      32'h0000_0040);

        // Flush during beat 2 of a fetch to 0x40
        req_valid = 1'b1; req_addr = 32'h0000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 6 && mem_addr != 10'h042; i++) @(negedge clk);
        check("flush_beat2_addr", 32'(mem_addr), 32'h0000_0042);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_rd_en", 32'(mem_rd_en),  32'd0);
        check("flush_ready", 32'(req_ready),  32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_no_resp", 32'(resp_valid), 32'd0);
        end
        run_req(32'h0000_0044, 32'h0000_000C, 1'b0, 0);

        // Asynchronous reset in the middle of a fetch
        req_valid = 1'b1; req_addr = 32'h0000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(req_ready), 32'd1);
        run_req(32'h0000_0040, 32'h2008_0005, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
Instruction-side responder at the far end of the fetch address path. It accepts a 32-bit byte address from the program-counter side over a valid/ready handshake. It reads the word as four big-endian bytes from a synchronous byte-wide instruction memory and returns the assembled instruction over a second valid/ready handshake. Misaligned and out-of-range addresses return an error response instead of data.

Parameters:
ADDR_W, 10, byte-address width of the attached instruction memory (depth 2**ADDR_W bytes); legal range 2..31.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
flush  input  1  synchronous abort of any in-flight request (branch/jump redirect).
req_valid  input  1  fetch address valid.
req_addr  input  32  byte address of instruction.
req_ready  output  1  responder can accept an address.
mem_rd_en  output  1  byte read strobe to memory.
mem_addr  output  ADDR_W  byte address to memory.
mem_rdata  input  8  read data; valid the cycle after the mem_rd_en cycle.
resp_valid  output  1  response valid.
resp_instr  output  32  assembled instruction; byte at base address in [31:24].
resp_addr  output  32  request address this response belongs to.
resp_err  output  1  request was misaligned or out of range.
resp_ready  input  1  consumer accepts response.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, beat=0, mem_rd_en=0, mem_addr=0, resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0. req_ready=1 after release.
- FSM states: IDLE, FETCH, DRAIN, RESP. Only one request is in flight at a time. req_ready=1 only in IDLE.
- IDLE: on the edge where req_valid&req_ready (edge E0), capture req_addr into resp_addr.
  - If req_addr[1:0]!=0 or req_addr[31:ADDR_W]!=0: resp_err=1, resp_instr=0, go to RESP. resp_valid is seen in the cycle after E0.
  - Otherwise: resp_err=0, beat=0, go to FETCH.
- FETCH: mem_rd_en=1, mem_addr={resp_addr[ADDR_W-1:2], beat[1:0]}. The beat counter increments each cycle 0..3. After beat 3 is issued, go to DRAIN.
- Data capture: on each edge where the previous cycle had mem_rd_en=1, shift in: resp_instr <= {resp_instr[23:0], mem_rdata}.
- DRAIN: mem_rd_en=0; captures the fourth byte, then goes to RESP.
- Aligned-fetch latency: 4 issue cycles + 1 drain cycle. resp_valid first high in the cycle after edge E5.
- RESP: resp_valid=1. resp_instr, resp_addr and resp_err are held stable while resp_ready=0. On resp_valid&resp_ready, go to IDLE; resp_valid=0 and req_ready=1 in the next cycle. A new request cannot be accepted in the same cycle as the handshake.
- Outside the capture/update edges, resp_instr and resp_addr hold their value. In IDLE they keep the last response; resp_valid=0.
- mem_rd_en is never asserted outside FETCH. mem_addr holds its last value when idle.
- flush=1 at an edge: next state=IDLE, mem_rd_en=0, resp_valid=0, beat=0. Any pending memory data is discarded, and no response is produced for the aborted request.
  - flush has priority over acceptance: with flush=1 and req_valid=1 in IDLE, nothing is captured. req_ready is still driven 1 in that cycle, but the request is not taken.
- Reset asserted mid-fetch or mid-response: immediate return to reset values. No partial response is ever presented.
- Address wrap: none. The highest legal word is 2**ADDR_W-4. The address 2**ADDR_W is out of range (error).

Test Plan:
- Memory bytes [0x40..0x43]=0x20,0x08,0x00,0x05; request 0x00000040 with resp_ready=1 -> mem_addr sequence 0x40,0x41,0x42,0x43 on 4 consecutive cycles; resp_valid 6th cycle after accept; resp_instr=0x20080005, resp_addr=0x40, resp_err=0; req_ready=1 the cycle after handshake.
- Request 0x00000042 -> no mem_rd_en; resp_valid the cycle after accept; resp_err=1, resp_instr=0, resp_addr=0x42.
- ADDR_W=10, request 0x00000400 -> error response as above. Request 0x000003FC -> normal 4-byte fetch of bytes 0x3FC..0x3FF.
- Aligned fetch with resp_ready=0 for 3 cycles after resp_valid -> outputs stable for all 4 cycles; single handshake; exactly one response.
- flush=1 during beat 2 of a fetch to 0x40, then request 0x44 (bytes 0x00,0x00,0x00,0x0C) -> no response for 0x40; response resp_instr=0x0000000C, resp_addr=0x44.
- reset pulsed low for 1 cycle during FETCH -> all outputs return to reset values immediately; after release req_ready=1 and the next fetch of 0x40 returns 0x20080005.
